// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state, requester-id types and byte-enable width for the memory port arbiter
package riscv_mem_pkg;
    localparam int BE_W = 4;
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} arb_state_t;
    typedef enum logic {REQ_IF, REQ_D} req_id_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating busy-cycle counter that flags a timeout; TIMEOUT_CYCLES=0 never expires
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // count enabled cycles, restart on clear, hold at all-ones
    always_comb begin
        cnt_d = clear ? '0 : (enable && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    // expires during the TIMEOUT_CYCLES-th enabled cycle since the last clear
    assign expired = (TIMEOUT_CYCLES != 0) && enable && cnt_q == LAST;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, with timeout abort.
// ARB_ROUND_ROBIN_EN: when defined, simultaneous requests alternate instead of data always winning.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [BE_W-1:0]       d_be,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [BE_W-1:0]       mem_be,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    arb_state_t state_q, state_d;
    req_id_t owner_q, owner_d;
    logic we_q, we_d, err_q, err_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic in_idle, busy, d_win, grant, expired;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t last_q, last_d;
    // on contention the requester not served last wins
    assign d_win = d_req && (!if_req || last_q == REQ_IF);
    // remember who was granted most recently
    always_comb begin
        last_d = d_gnt ? REQ_D : if_gnt ? REQ_IF : last_q;
    end
    // last-owner flag; starts as fetch so data wins the first contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= REQ_IF;
        else        last_q <= last_d;
    end
`else
    assign d_win = d_req;
`endif

    // grants are combinational and suppressed while reset is held
    assign in_idle = reset && state_q == IDLE;
    assign busy    = state_q == BUSY_IF || state_q == BUSY_D;
    assign d_gnt   = in_idle && d_win;
    assign if_gnt  = in_idle && if_req && !d_win;
    assign grant   = d_gnt || if_gnt;

    // next state: latch the granted access, finish on ready (beats timeout), then one response cycle
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (grant) begin
            state_d = d_gnt ? BUSY_D : BUSY_IF;
            owner_d = d_gnt ? REQ_D : REQ_IF;
            we_d    = d_gnt && d_we;
            be_d    = d_gnt ? d_be : '1;
            addr_d  = d_gnt ? d_addr : if_addr;
            wdata_d = d_gnt ? d_wdata : '0;
        end else if (busy && (mem_ready || expired)) begin
            state_d = RESP;
            rdata_d = (mem_ready && !we_q) ? mem_rdata : '0;
            err_d   = !mem_ready;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    // state and access registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= REQ_IF;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant),
        .enable  (busy),
        .expired (expired)
    );

    assign if_rvalid = state_q == RESP && owner_q == REQ_IF;
    assign d_rvalid  = state_q == RESP && owner_q == REQ_D;
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_be    = busy ? be_q : '0;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter; ARB_ROUND_ROBIN_EN switches the contention expectation
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int TO = 16;
    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic if_req, d_req, d_we, mem_ready;
    logic [DW-1:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0] d_be;
    logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    exp_t sb[$];
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; if_addr = 32'h44; d_addr = 32'h88;
        d_wdata = 32'h1; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) cyc();
        vectors++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_req, mem_we, mem_be,
             mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b mem_req=%b mem_addr=%h, want all zero",
                     if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_addr);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_fetch();
        cyc();
        if_req = 1; if_addr = 32'h100;
        #1;
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt: got if/d=%b%b want 10", if_gnt, d_gnt);
        end
        sb.push_back('{is_d: 1'b0, rdata: 32'h0050_0093, err: 1'b0});
        cyc();
        if_req = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
                errors++;
                $display("FAIL fetch_mem_hold[%0d]: got req=%b we=%b be=%h addr=%h want 1 0 f 00000100",
                         i, mem_req, mem_we, mem_be, mem_addr);
            end
            if (i == 2) begin mem_ready = 1; mem_rdata = 32'h0050_0093; end
            cyc();
        end
        mem_ready = 0; mem_rdata = 32'h1111_2222;
        vectors++;
        if ({if_rvalid, mem_req} !== 2'b10) begin
            errors++; $display("FAIL fetch_rvalid_time: got rvalid=%b mem_req=%b want 1 0", if_rvalid, mem_req);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        cyc();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400;
        #1;
        vectors++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL b2b_gnt0: got d/if=%b%b want 10", d_gnt, if_gnt);
        end
        sb.push_back('{is_d: 1'b1, rdata: 32'hA5A5_0001, err: 1'b0});
        cyc();
        mem_ready = 1; mem_rdata = 32'hA5A5_0001;
        vectors++;
        if ({mem_req, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL b2b_busy: got mem_req=%b d_gnt=%b want 1 0", mem_req, d_gnt);
        end
        cyc();
        mem_ready = 0; mem_rdata = 32'h0BAD_0BAD;
        vectors++;
        if ({d_rvalid, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL b2b_resp: got d_rvalid=%b d_gnt=%b want 1 0", d_rvalid, d_gnt);
        end
        cyc();
        d_addr = 32'h404;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt1: got d_gnt=%b want 1", d_gnt);
        end
        sb.push_back('{is_d: 1'b1, rdata: 32'hA5A5_0002, err: 1'b0});
        cyc();
        d_req = 0; mem_ready = 1; mem_rdata = 32'hA5A5_0002;
        vectors++;
        if (mem_addr !== 32'h404) begin
            errors++; $display("FAIL b2b_addr1: got %h want 00000404", mem_addr);
        end
        cyc();
        mem_ready = 0;
        cyc();
    endtask

    task automatic test_priority();
        cyc();
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        #1;
        vectors++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL prio_gnt: got d/if=%b%b want 10", d_gnt, if_gnt);
        end
        sb.push_back('{is_d: 1'b1, rdata: '0, err: 1'b0});
        cyc();
        d_req = 0; d_we = 0; mem_ready = 1; mem_rdata = 32'h1234_5678;
        vectors++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt} !==
            {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL prio_write: got req=%b we=%b be=%h addr=%h wdata=%h if_gnt=%b want 1 1 3 00002000 deadbeef 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_gnt);
        end
        cyc();
        mem_ready = 0;
        vectors++;
        if ({d_rvalid, if_gnt} !== 2'b10) begin
            errors++; $display("FAIL prio_resp: got d_rvalid=%b if_gnt=%b want 1 0", d_rvalid, if_gnt);
        end
        cyc();
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL prio_if_after: got if/d=%b%b want 10", if_gnt, d_gnt);
        end
        sb.push_back('{is_d: 1'b0, rdata: 32'hCAFE_0001, err: 1'b0});
        cyc();
        if_req = 0; mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        vectors++;
        if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 32'h300}) begin
            errors++; $display("FAIL prio_fetch_mem: got we=%b be=%h addr=%h want 0 f 00000300", mem_we, mem_be, mem_addr);
        end
        cyc();
        mem_ready = 0;
        cyc();
    endtask

    task automatic test_timeout(input logic ready_last);
        cyc();
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h40; mem_rdata = 32'hFFFF_0000;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL to_gnt: got %b want 1", d_gnt);
        end
        sb.push_back('{is_d: 1'b1, rdata: ready_last ? 32'h77 : 32'h0, err: !ready_last});
        cyc();
        d_req = 0;
        for (int i = 0; i < TO; i++) begin
            vectors++;
            if ({mem_req, d_rvalid} !== 2'b10) begin
                errors++; $display("FAIL to_busy[%0d]: got mem_req=%b d_rvalid=%b want 1 0", i, mem_req, d_rvalid);
            end
            if (ready_last && i == TO - 1) begin mem_ready = 1; mem_rdata = 32'h77; end
            cyc();
        end
        mem_ready = 0;
        vectors++;
        if ({mem_req, d_rvalid, d_err} !== {1'b0, 1'b1, !ready_last}) begin
            errors++;
            $display("FAIL to_end(ready=%b): got mem_req=%b d_rvalid=%b d_err=%b want 0 1 %b",
                     ready_last, mem_req, d_rvalid, d_err, !ready_last);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        cyc();
        d_req = 1; d_we = 1; d_be = 4'hC; d_addr = 32'h80; d_wdata = 32'h55;
        #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL rmid_gnt: got %b want 1", d_gnt);
        end
        cyc();
        d_req = 0;
        cyc();
        vectors++;
        if ({mem_req, mem_we, mem_be} !== {1'b1, 1'b1, 4'hC}) begin
            errors++; $display("FAIL rmid_busy: got req=%b we=%b be=%h want 1 1 c", mem_req, mem_we, mem_be);
        end
        reset = 0; mem_ready = 1; mem_rdata = 32'h99;
        #1;
        vectors++;
        if ({d_gnt, if_gnt, d_rvalid, d_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL rmid_async: got mem_req=%b we=%b be=%h addr=%h wdata=%h want all zero",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        repeat (3) cyc();
        mem_ready = 0;
        @(negedge clk);
        reset = 1;
        if_req = 1; if_addr = 32'h500;
        #1;
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL rmid_first_gnt: got if/d=%b%b want 10", if_gnt, d_gnt);
        end
        sb.push_back('{is_d: 1'b0, rdata: 32'h600D, err: 1'b0});
        cyc();
        if_req = 0; mem_ready = 1; mem_rdata = 32'h600D;
        vectors++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h500}) begin
            errors++; $display("FAIL rmid_after: got req=%b we=%b addr=%h want 1 0 00000500", mem_req, mem_we, mem_addr);
        end
        cyc();
        mem_ready = 0;
        cyc();
    endtask

    task automatic test_contention();
        logic exp_d;
        cyc();
        if_req = 1; if_addr = 32'h700; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h900;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            vectors++;
            if ({d_gnt, if_gnt} !== {exp_d, !exp_d}) begin
                errors++; $display("FAIL cont_gnt[%0d]: got d/if=%b%b want %b%b", i, d_gnt, if_gnt, exp_d, !exp_d);
            end
            sb.push_back('{is_d: exp_d, rdata: 32'h1000 + i, err: 1'b0});
            cyc();
            mem_ready = 1; mem_rdata = 32'h1000 + i;
            vectors++;
            if (mem_addr !== (exp_d ? 32'h900 : 32'h700)) begin
                errors++; $display("FAIL cont_addr[%0d]: got %h want %h", i, mem_addr, exp_d ? 32'h900 : 32'h700);
            end
            cyc();
            mem_ready = 0;
            cyc();
        end
        if_req = 0; d_req = 0;
        cyc();
    endtask

    initial begin
        clear_inputs();
        fork
            begin
                exp_t e;
                logic [2*DW+3:0] got, want;
                forever begin
                    @(negedge clk);
                    if (if_rvalid || d_rvalid) begin
                        vectors++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL rvalid_unexpected: got if_rvalid=%b d_rvalid=%b want none", if_rvalid, d_rvalid);
                        end else begin
                            e = sb.pop_front();
                            got  = {if_rvalid, d_rvalid, if_rdata, d_rdata, if_err, d_err};
                            want = {!e.is_d, e.is_d, e.is_d ? {DW{1'b0}} : e.rdata,
                                    e.is_d ? e.rdata : {DW{1'b0}}, !e.is_d && e.err, e.is_d && e.err};
                            if (got !== want) begin
                                errors++;
                                $display("FAIL sb_resp: got %h want %h (rv_if,rv_d,rdata_if,rdata_d,err_if,err_d)", got, want);
                            end
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_fetch();
        test_back_to_back();
        test_priority();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_contention();
        repeat (2) cyc();
        vectors++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending responses want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
